// File: rtl/partition_pkg.sv
`default_nettype none
// ============================================================================
// Module   : partition_pkg
// Brief    : Types, field widths and the transition function for the
//            dynamic-partition sequencer.
// Revision : 1.0
// ============================================================================
package partition_pkg;

    localparam int CNT_W = 3;
    localparam int PH_W  = 2;

    typedef struct packed {
        logic             m1;
        logic             m0;
        logic [CNT_W-1:0] b;
        logic [CNT_W-1:0] a;
    } state_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ctrl_state_e;

    // Phase walks the Johnson ring 00->01->11->10; odd-parity phases bump b.
    function automatic state_t next_state(input state_t s);
        state_t          n;
        logic [PH_W-1:0] ph;
        n  = s;
        ph = {s.m1, s.m0};
        if (^ph) begin
            n.b = s.b + CNT_W'(1);
        end else begin
            n.a = s.a + CNT_W'(1);
        end
        n.m0 = ~ph[1];
        n.m1 = ph[0];
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/partition_hist_cam.sv
`default_nettype none
// ============================================================================
// Module   : partition_hist_cam
// Brief    : History of visited states with single write port, bulk clear and
//            a parallel compare reporting the lowest matching slot.
// Revision : 1.0
// ============================================================================
module partition_hist_cam
    import partition_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  state_t           wr_data,
    input  state_t           cmp_key,
    output logic             hit,
    output logic [IDX_W-1:0] hit_idx
);

    state_t             r_mem [DEPTH];
    logic [DEPTH-1:0]   r_valid;
    logic [DEPTH-1:0]   w_match;

    // A clear and a write in the same cycle leave only the written slot valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else begin
            if (clear) begin
                r_valid <= '0;
            end
            if (wr_en) begin
                r_valid[wr_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_idx] <= wr_data;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
            assign w_match[gi] = r_valid[gi] && (r_mem[gi] == cmp_key);
        end
    endgenerate

    assign hit = |w_match;

    // Descending scan so the lowest matching slot is the last one written.
    always_comb begin
        hit_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                hit_idx = IDX_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/partition_fixpoint_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : partition_fixpoint_ctrl
// Brief    : Steps the partition transition from a loaded state until a state
//            repeats or the history fills, then offers the verdict on valid/ready.
// Revision : 1.0
// ============================================================================
module partition_fixpoint_ctrl
    import partition_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int STEP_W = $clog2(DEPTH) + 1,
    parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              start_ready,
    input  logic [7:0]        init_state,
    input  logic              hold,
    input  logic              abort,
    output logic              busy,
    output logic [7:0]        cur_state,
    output logic              done_valid,
    input  logic              done_ready,
    output logic              found,
    output logic [STEP_W-1:0] steps,
    output logic [IDX_W-1:0]  match_idx
);

    localparam logic [STEP_W-1:0] c_depth = STEP_W'(DEPTH);

    ctrl_state_e       r_state;
    ctrl_state_e       w_state_nx;
    state_t            r_cur;
    state_t            w_nxt;
    logic [STEP_W-1:0] r_count;
    logic [STEP_W-1:0] r_steps;
    logic              r_found;
    logic [IDX_W-1:0]  r_match_idx;

    logic              w_hit;
    logic [IDX_W-1:0]  w_hit_idx;
    logic              w_cam_clear;
    logic              w_cam_we;
    logic [IDX_W-1:0]  w_cam_widx;
    state_t            w_cam_wdata;
    logic              w_accept;
    logic              w_advance;
    logic              w_exhaust;

    assign w_nxt     = next_state(r_cur);
    assign w_exhaust = (r_count == c_depth);

    partition_hist_cam #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_hist (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_cam_clear),
        .wr_en   (w_cam_we),
        .wr_idx  (w_cam_widx),
        .wr_data (w_cam_wdata),
        .cmp_key (w_nxt),
        .hit     (w_hit),
        .hit_idx (w_hit_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Abort outranks hold and any decision; a hit outranks exhaustion.
    always_comb begin
        w_state_nx  = r_state;
        w_cam_clear = 1'b0;
        w_cam_we    = 1'b0;
        w_cam_widx  = r_count[IDX_W-1:0];
        w_cam_wdata = w_nxt;
        w_accept    = 1'b0;
        w_advance   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nx  = RUN;
                    w_cam_clear = 1'b1;
                    w_cam_we    = 1'b1;
                    w_cam_widx  = '0;
                    w_cam_wdata = state_t'(init_state);
                end
            end
            RUN: begin
                if (abort) begin
                    w_state_nx  = IDLE;
                    w_cam_clear = 1'b1;
                end else if (!hold) begin
                    w_advance = 1'b1;
                    if (w_hit || w_exhaust) begin
                        w_state_nx = DONE;
                    end else begin
                        w_cam_we = 1'b1;
                    end
                end
            end
            DONE: begin
                if (done_ready) begin
                    w_state_nx = IDLE;
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cur       <= '0;
            r_count     <= '0;
            r_steps     <= '0;
            r_found     <= 1'b0;
            r_match_idx <= '0;
        end else if (w_accept) begin
            r_cur       <= state_t'(init_state);
            r_count     <= STEP_W'(1);
            r_steps     <= '0;
            r_found     <= 1'b0;
            r_match_idx <= '0;
        end else if (w_advance) begin
            r_steps <= r_steps + STEP_W'(1);
            if (w_hit) begin
                r_found     <= 1'b1;
                r_match_idx <= w_hit_idx;
            end else if (w_exhaust) begin
                r_found     <= 1'b0;
                r_match_idx <= '0;
            end else begin
                r_cur   <= w_nxt;
                r_count <= r_count + STEP_W'(1);
            end
        end
    end

    assign start_ready = (r_state == IDLE);
    assign busy        = (r_state == RUN);
    assign done_valid  = (r_state == DONE);
    assign cur_state   = r_cur;
    assign found       = r_found;
    assign steps       = r_steps;
    assign match_idx   = r_match_idx;

endmodule
`default_nettype wire
